hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter LOAD_LAT, default 1: stall cycles between a load issuing to X and a dependent consumer issuing; legal range 0..7.
REQ-002 Parameter ALU_LAT, default 0: same for ALU/LUI/AUIPC/JAL/JALR producers; 0 means full bypass, 3 means no bypass; legal range 0..7.
REQ-003 Parameter LONG_DEPTH, default 2: maximum outstanding long-latency (MUL/DIV) ops; legal range 1..4.
REQ-004 Parameter HAS_M, default 1: when 0, opcode 01100 with funct7=0000001 is treated as an ALU op.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 d_valid  input  1  the instruction in D is valid.
REQ-008 d_instr  input  32  the instruction in D.
REQ-009 flush  input  1  kills the instruction in D this cycle.
REQ-010 ext_done  input  1  the long unit writes back this cycle.
REQ-011 ext_rd  input  5  destination of the completing long op.
REQ-012 rs1, rs2  output  5 each  source fields; rs1 is forced to 0 for LUI (opcode 01101).
REQ-013 stall_F_D  output  1  holds F and D.
REQ-014 issue  output  1  the D instruction advances to X this cycle.
REQ-015 pending  output  32  bit r is set when x_r has a nonzero counter or long-busy bit; bit 0 is always 0.
REQ-016 long_outstanding  output  3  count of in-flight long ops.

Function
REQ-017 Each register r (1..31) SHALL have a 3-bit counter cnt[r] and a busy bit lbusy[r]; x0 is never tracked.
REQ-018 Producers: every opcode except 11000 (B) and 01000 (S) with rd!=0; load = opcode 00000; long = opcode 01100, funct7 0000001, HAS_M=1.
REQ-019 Source usage: rs1 is used by all opcodes except 01101, 00101 and 11011; rs2 is used only by 11000, 01000 and 01100.
REQ-020 raw_hit SHALL assert for a used source s!=0 with cnt[s]!=0 or lbusy[s]=1.
REQ-021 waw_hit SHALL assert for a producer whose rd has lbusy[rd]=1.
REQ-022 struct_hit SHALL assert for a long op when long_outstanding==LONG_DEPTH.
REQ-023 stall_F_D = d_valid & !flush & (raw_hit | waw_hit | struct_hit); all terms come from registered state only.
REQ-024 issue = d_valid & !flush & !stall_F_D.
REQ-025 At each edge, every nonzero cnt SHALL decrement by 1.
REQ-026 On issue of a non-long producer, cnt[rd] SHALL load LOAD_LAT or ALU_LAT; this overrides the same-edge decrement.
REQ-027 On issue of a long op, lbusy[rd] SHALL set, cnt[rd] SHALL clear, and long_outstanding SHALL increment.
REQ-028 On ext_done with ext_rd!=0, lbusy[ext_rd] SHALL clear and long_outstanding SHALL decrement; the stall from that register drops the cycle after ext_done.
REQ-029 ext_done when long_outstanding==0 SHALL be ignored (no underflow).
REQ-030 Long issue and ext_done on the same edge SHALL leave long_outstanding unchanged; ext_done to rd and a new long issue to the same rd cannot coincide, because waw_hit blocks the issue.
REQ-031 Flush SHALL suppress issue only; counters and busy bits continue to evolve.
REQ-032 A non-issuing cycle SHALL modify no counter except by decrement.

Reset
REQ-033 While rst_n=0: all cnt=0, all lbusy=0, long_outstanding=0, pending=0; stall_F_D is 0 independent of d_instr; the clear takes effect immediately, even mid-operation.
REQ-034 The first edge after reset release SHALL operate normally.

Verification
REQ-035 Defaults: lw x5 issues, then add x6,x5,x1 is in D -> stall_F_D=1 for exactly 1 cycle, issue on the 2nd cycle.
REQ-036 ALU_LAT=0: addi x5 followed by add x7,x5,x5 -> no stall; with ALU_LAT=3 -> 3 stall cycles, pending[5] high for 3 cycles.
REQ-037 mul x8 issues, then add x9,x8,x0 in D; ext_done (ext_rd=8) 5 cycles later -> stall for 6 cycles total, pending[8] clears the cycle after ext_done.
REQ-038 LONG_DEPTH=2: mul x1, mul x2 issue, then mul x3 -> stall until the first ext_done, issue next cycle, long_outstanding 2->1->2.
REQ-039 Load to x0, or sw x5 with cnt[5]=0 -> no stall; sw x5,0(x6) with cnt[5]=1 -> stall via rs2; lui x5 with cnt[field rs1]!=0 -> no stall.
REQ-040 rst_n low with lbusy[4]=1 and long_outstanding=1 -> pending=0, long_outstanding=0, stall_F_D=0 asynchronously; a spurious ext_done afterwards is ignored.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard -- in-order issue interlock for the D -> X boundary.
//
// Tracks, for every architectural register x1..x31, a short-latency countdown
// (cnt) and a long-latency busy bit (lbusy). The instruction in D is stalled
// on a RAW dependence, a WAW on a long-busy destination, or a full long unit.
// All hazard terms derive from registered state plus the D instruction, so
// stall_F_D has no path from ext_done or flush-into-state.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   d_valid, d_instr  instruction in D
//   flush             kill the D instruction this cycle (state keeps evolving)
//   ext_done, ext_rd  long-latency unit writeback
//   rs1, rs2          decoded source fields (rs1 forced to 0 for LUI)
//   stall_F_D         hold F and D
//   issue             D advances to X this cycle
//   pending           per-register in-flight indication (bit 0 always 0)
//   long_outstanding  number of in-flight long ops
module hazard_scoreboard #(
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned ALU_LAT    = 0,
    parameter int unsigned LONG_DEPTH = 2,
    parameter int unsigned HAS_M      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        d_valid,
    input  logic [31:0] d_instr,
    input  logic        flush,
    input  logic        ext_done,
    input  logic [4:0]  ext_rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        stall_F_D,
    output logic        issue,
    output logic [31:0] pending,
    output logic [2:0]  long_outstanding
);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [2:0] LOAD_CNT = 3'(LOAD_LAT);
    localparam logic [2:0] ALU_CNT  = 3'(ALU_LAT);
    localparam logic [2:0] LONG_MAX = 3'(LONG_DEPTH);

    logic [31:0][2:0] cnt_q, cnt_d;
    logic [31:0]      lbusy_q, lbusy_d;
    logic [2:0]       long_q, long_d;

    logic [4:0] opcode, rd_f;
    logic [6:0] funct7;
    logic       is_producer, is_long, is_load, use_rs1, use_rs2;
    logic       raw_hit, waw_hit, struct_hit;
    logic       ext_accept, long_inc;

    logic unused_instr_bits;
    assign unused_instr_bits = ^{d_instr[1:0], d_instr[14:12]};

    // Decode
    always_comb begin
        opcode      = d_instr[6:2];
        rd_f        = d_instr[11:7];
        funct7      = d_instr[31:25];
        rs1         = (opcode == OPC_LUI) ? 5'd0 : d_instr[19:15];
        rs2         = d_instr[24:20];
        is_producer = (opcode != OPC_BRANCH) && (opcode != OPC_STORE) && (rd_f != 5'd0);
        is_long     = is_producer && (HAS_M != 0) && (opcode == OPC_OP) &&
                      (funct7 == F7_MULDIV);
        is_load     = (opcode == OPC_LOAD);
        use_rs1     = (opcode != OPC_LUI) && (opcode != OPC_AUIPC) && (opcode != OPC_JAL);
        use_rs2     = (opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP);
    end

    // Per-register in-flight view; x0 is never tracked.
    always_comb begin
        pending = '0;
        for (int r = 1; r < 32; r++) begin
            pending[r] = (cnt_q[r] != 3'd0) || lbusy_q[r];
        end
    end

    // pending[0] is hard 0, so a zero source index never hits.
    always_comb begin
        raw_hit    = (use_rs1 && pending[rs1]) || (use_rs2 && pending[rs2]);
        waw_hit    = is_producer && lbusy_q[rd_f];
        struct_hit = is_long && (long_q == LONG_MAX);
        stall_F_D  = d_valid && !flush && (raw_hit || waw_hit || struct_hit);
        issue      = d_valid && !flush && !stall_F_D;
    end

    // A completion with nothing outstanding is spurious and dropped entirely.
    assign ext_accept       = ext_done && (ext_rd != 5'd0) && (long_q != 3'd0);
    assign long_inc         = issue && is_long;
    assign long_outstanding = long_q;

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = (cnt_q[r] != 3'd0) ? cnt_q[r] - 3'd1 : 3'd0;
        end
        lbusy_d = lbusy_q;
        if (ext_accept) begin
            lbusy_d[ext_rd] = 1'b0;
        end
        // Issue load overrides the same-edge decrement of the destination.
        if (issue && is_producer) begin
            if (is_long) begin
                lbusy_d[rd_f] = 1'b1;
                cnt_d[rd_f]   = 3'd0;
            end else begin
                cnt_d[rd_f] = is_load ? LOAD_CNT : ALU_CNT;
            end
        end
        cnt_d[0]   = 3'd0;
        lbusy_d[0] = 1'b0;

        unique case ({long_inc, ext_accept})
            2'b10:   long_d = long_q + 3'd1;
            2'b01:   long_d = long_q - 3'd1;
            default: long_d = long_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            lbusy_q <= '0;
            long_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            lbusy_q <= lbusy_d;
            long_q  <= long_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] MULF7  = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        d_valid = 1'b0;
    logic [31:0] d_instr = '0;
    logic        flush = 1'b0;
    logic        ext_done = 1'b0;
    logic [4:0]  ext_rd = '0;
    logic [4:0]  rs1, rs2;
    logic        stall_F_D, issue;
    logic [31:0] pending;
    logic [2:0]  long_outstanding;

    // Second instance with ALU_LAT=3 (no bypass)
    logic        d_valid3 = 1'b0;
    logic [31:0] d_instr3 = '0;
    logic [4:0]  rs1_3, rs2_3;
    logic        stall3, issue3;
    logic [31:0] pending3;
    logic [2:0]  long3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        int          stalls;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .d_valid          (d_valid),
        .d_instr          (d_instr),
        .flush            (flush),
        .ext_done         (ext_done),
        .ext_rd           (ext_rd),
        .rs1              (rs1),
        .rs2              (rs2),
        .stall_F_D        (stall_F_D),
        .issue            (issue),
        .pending          (pending),
        .long_outstanding (long_outstanding)
    );

    hazard_scoreboard #(.ALU_LAT(3)) dut3 (
        .clk              (clk),
        .rst_n            (rst_n),
        .d_valid          (d_valid3),
        .d_instr          (d_instr3),
        .flush            (1'b0),
        .ext_done         (1'b0),
        .ext_rd           (5'd0),
        .rs1              (rs1_3),
        .rs2              (rs2_3),
        .stall_F_D        (stall3),
        .issue            (issue3),
        .pending          (pending3),
        .long_outstanding (long3)
    );

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {f7, s2, s1, 3'b000, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] s1, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {12'd1, s1, 3'b010, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] s2, input logic [4:0] s1);
        return {7'd0, s2, s1, 3'b010, 5'd0, STORE};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts stall cycles of the D instruction, scores each issue.
    initial begin
        int   stall_run;
        exp_t e;
        stall_run = 0;
        forever begin
            @(negedge clk);
            if (rst_n && d_valid && !flush) begin
                if (stall_F_D) begin
                    stall_run++;
                end else if (issue) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_issue: got %h expected none", d_instr);
                    end else begin
                        e = exp_q.pop_front();
                        check("issue_instr", d_instr, e.instr);
                        check("stall_cycles", 32'(stall_run), 32'(e.stalls));
                    end
                    stall_run = 0;
                end
            end
        end
    end

    // Present instr in D until it issues; ext_done pulses in cycle ext_after.
    task automatic present(input logic [31:0] instr, input int stalls,
                           input int ext_after = -1, input logic [4:0] ext_r = 5'd0);
        exp_t e;
        e.instr  = instr;
        e.stalls = stalls;
        exp_q.push_back(e);
        for (int i = 0; ; i++) begin
            @(posedge clk);
            #1;
            d_valid  = 1'b1;
            d_instr  = instr;
            flush    = 1'b0;
            ext_done = (i == ext_after);
            ext_rd   = ext_r;
            @(negedge clk);
            if (issue) break;
            if (i >= 20) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout: got no issue expected issue of %h", instr);
                void'(exp_q.pop_back());
                break;
            end
        end
    endtask

    task automatic idle(input logic ext = 1'b0, input logic [4:0] r = 5'd0);
        @(posedge clk);
        #1;
        d_valid  = 1'b0;
        flush    = 1'b0;
        ext_done = ext;
        ext_rd   = r;
        @(negedge clk);
    endtask

    task automatic peek(input logic [31:0] instr, input logic [4:0] e1, input logic [4:0] e2);
        @(posedge clk);
        #1;
        d_valid  = 1'b0;
        d_instr  = instr;
        ext_done = 1'b0;
        @(negedge clk);
        check("rs1_field", 32'(rs1), 32'(e1));
        check("rs2_field", 32'(rs2), 32'(e2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] lw5, add6, lui10;
        lw5   = enc_i(5'd1, 5'd5, LOAD);
        add6  = enc_r(7'd0, 5'd1, 5'd5, 5'd6, OP);
        lui10 = enc_r(7'd0, 5'd0, 5'd5, 5'd10, LUI);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        d_valid = 1'b1;
        d_instr = add6;
        #1;
        check("reset_stall", 32'(stall_F_D), 32'd0);
        check("reset_pending", pending, 32'd0);
        check("reset_long", 32'(long_outstanding), 32'd0);
        d_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Load latency visible in pending
        present(lw5, 0);
        idle();
        check("load_pending_set", pending, 32'h0000_0020);
        idle();
        check("load_pending_clear", pending, 32'd0);

        // Load-use: one stall
        present(lw5, 0);
        present(add6, 1);

        // Full ALU bypass
        present(enc_i(5'd0, 5'd5, OPIMM), 0);
        present(enc_r(7'd0, 5'd5, 5'd5, 5'd7, OP), 0);
        idle();
        check("alu_bypass_pending", pending, 32'd0);

        // Load to x0 is not tracked; store with clear source does not stall
        present(enc_i(5'd1, 5'd0, LOAD), 0);
        idle();
        check("x0_untracked", pending, 32'd0);
        present(enc_s(5'd5, 5'd6), 0);

        // Store data dependence via rs2
        present(lw5, 0);
        present(enc_s(5'd5, 5'd6), 1);

        // LUI ignores its rs1 field
        present(lw5, 0);
        present(lui10, 0);
        peek(lui10, 5'd0, 5'd0);
        peek(add6, 5'd5, 5'd1);

        // Flush kills issue but the counter still drains
        present(lw5, 0);
        @(posedge clk);
        #1;
        d_valid = 1'b1;
        d_instr = add6;
        flush   = 1'b1;
        @(negedge clk);
        check("flush_stall", 32'(stall_F_D), 32'd0);
        check("flush_issue", 32'(issue), 32'd0);
        present(add6, 0);

        // Long op dependence released by ext_done
        present(enc_r(MULF7, 5'd2, 5'd1, 5'd8, OP), 0);
        idle();
        check("mul_pending", pending, 32'h0000_0100);
        check("mul_long1", 32'(long_outstanding), 32'd1);
        present(enc_r(7'd0, 5'd0, 5'd8, 5'd9, OP), 6, 5, 5'd8);
        check("mul_release_pending", pending, 32'd0);
        check("mul_release_long", 32'(long_outstanding), 32'd0);

        // Structural limit on long ops
        present(enc_r(MULF7, 5'd3, 5'd2, 5'd1, OP), 0);
        present(enc_r(MULF7, 5'd5, 5'd4, 5'd2, OP), 0);
        idle();
        check("struct_long2", 32'(long_outstanding), 32'd2);
        check("struct_pending2", pending, 32'h0000_0006);
        present(enc_r(MULF7, 5'd7, 5'd6, 5'd3, OP), 4, 3, 5'd1);
        check("struct_long_dip", 32'(long_outstanding), 32'd1);
        check("struct_pending_dip", pending, 32'h0000_0004);
        idle();
        check("struct_long_back", 32'(long_outstanding), 32'd2);
        check("struct_pending_back", pending, 32'h0000_000C);
        idle(1'b1, 5'd2);
        idle(1'b1, 5'd3);
        idle();
        check("drain_long", 32'(long_outstanding), 32'd0);
        check("drain_pending", pending, 32'd0);

        // Asynchronous reset mid-operation
        present(enc_r(MULF7, 5'd2, 5'd1, 5'd4, OP), 0);
        idle();
        check("pre_reset_long", 32'(long_outstanding), 32'd1);
        check("pre_reset_pending", pending, 32'h0000_0010);
        @(posedge clk);
        #1;
        d_valid = 1'b1;
        d_instr = enc_r(7'd0, 5'd0, 5'd4, 5'd5, OP);
        #1;
        check("pre_reset_stall", 32'(stall_F_D), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_pending", pending, 32'd0);
        check("async_long", 32'(long_outstanding), 32'd0);
        check("async_stall", 32'(stall_F_D), 32'd0);
        @(negedge clk);
        d_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1, 5'd4);
        idle();
        check("spurious_ext_long", 32'(long_outstanding), 32'd0);
        check("spurious_ext_pending", pending, 32'd0);

        // First edge after release behaves normally
        present(lw5, 0);
        idle();
        check("post_reset_load", pending, 32'h0000_0020);

        // ALU_LAT=3: three stall cycles, pending[5] follows them
        @(posedge clk);
        #1;
        d_valid3 = 1'b1;
        d_instr3 = enc_i(5'd0, 5'd5, OPIMM);
        @(negedge clk);
        check("lat3_addi_issue", 32'(issue3), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            d_instr3 = enc_r(7'd0, 5'd5, 5'd5, 5'd7, OP);
            @(negedge clk);
            check("lat3_stall", 32'(stall3), (i < 3) ? 32'd1 : 32'd0);
            check("lat3_pending5", 32'(pending3[5]), (i < 3) ? 32'd1 : 32'd0);
        end
        check("lat3_issue", 32'(issue3), 32'd1);
        @(posedge clk);
        #1;
        d_valid3 = 1'b0;
        @(negedge clk);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
